ir_nec_decoder: RTL



---
 rtl/ir_nec_pkg.sv | 33 +++
 rtl/ir_pulse_timer.sv | 77 +++++++
 rtl/ir_nec_decoder.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/ir_nec_pkg.sv
`timescale 1ns/1ps
// ir_nec_pkg: shared types and constants for the NEC IR decoder.
// FSM state encoding, width-counter size and nominal NEC protocol timings.
// Optional checksum enforcement is selected with the IR_NEC_CHECKSUM_EN macro.
package ir_nec_pkg;

    // Pulse width counter width in microsecond ticks (covers the 20 ms timeout)
    localparam int WIDTH_W  = 15;
    // Bit index width for a 32-bit NEC frame
    localparam int BITCNT_W = 5;

    // Nominal NEC timings in microseconds
    localparam int NEC_LEAD_MARK_US  = 9000;
    localparam int NEC_LEAD_SPACE_US = 4500;
    localparam int NEC_RPT_SPACE_US  = 2250;
    localparam int NEC_BIT_MARK_US   = 562;
    localparam int NEC_ZERO_SPACE_US = 562;
    localparam int NEC_ONE_SPACE_US  = 1687;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LEAD_MARK  = 3'd1,
        ST_LEAD_SPACE = 3'd2,
        ST_BIT_MARK   = 3'd3,
        ST_BIT_SPACE  = 3'd4
    } state_t;

    // NEC integrity rule: each data byte is followed by its bitwise inverse
    function automatic logic nec_checksum_ok(input logic [31:0] f);
        return (f[15:8] == ~f[7:0]) && (f[31:24] == ~f[23:16]);
    endfunction

endpackage

// File: rtl/ir_pulse_timer.sv
`timescale 1ns/1ps
// ir_pulse_timer: conditions the raw IR pin and measures time between edges.
// Two-flop synchronizer, registered fall/rise detection, a 1 us prescaler and a
// saturating width counter. Prescaler and width restart on every detected edge,
// one cycle after the edge pulse is presented, so the consumer sees the full
// width of the interval that the edge just closed.
module ir_pulse_timer
    import ir_nec_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int TIMEOUT_US = 20000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_rx_n,
    output logic               o_fall,
    output logic               o_rise,
    output logic [WIDTH_W-1:0] o_width
);

    localparam int                 PRE_W       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PRE_W-1:0]   LP_PRE_LAST = PRE_W'(CLK_DIV - 1);
    localparam logic [WIDTH_W-1:0] LP_TIMEOUT  = WIDTH_W'(TIMEOUT_US);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync3;
    logic               r_fall;
    logic               r_rise;
    logic [PRE_W-1:0]   r_pre;
    logic [WIDTH_W-1:0] r_width;
    logic               w_tick;
    logic               w_edge;

    assign w_tick = (r_pre == LP_PRE_LAST);
    assign w_edge = r_fall | r_rise;

    // Synchronize the pin (idle high) and register one-cycle edge pulses
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_sync3 <= 1'b1;
            r_fall  <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_sync1 <= i_rx_n;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_fall  <= r_sync3 & ~r_sync2;
            r_rise  <= ~r_sync3 & r_sync2;
        end
    end

    // Microsecond prescaler and saturating width counter, both restarted by an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre   <= '0;
            r_width <= '0;
        end else if (w_edge) begin
            r_pre   <= '0;
            r_width <= '0;
        end else if (w_tick) begin
            r_pre <= '0;
            if (r_width < LP_TIMEOUT) begin
                r_width <= r_width + WIDTH_W'(1);
            end
        end else begin
            r_pre <= r_pre + PRE_W'(1);
        end
    end

    assign o_fall  = r_fall;
    assign o_rise  = r_rise;
    assign o_width = r_width;

endmodule

// File: rtl/ir_nec_decoder.sv
`timescale 1ns/1ps
// ir_nec_decoder: NEC remote-control frame decoder for the IR PIO input.
// Decodes leader, 32 data bits (LSB first) and repeat codes from the active-low
// receiver pin. Emits one-cycle valid/repeat/error strobes and a sticky
// data_ready level cleared by ack. Define IR_NEC_CHECKSUM_EN to reject frames
// whose address/command bytes are not followed by their inverses.
module ir_nec_decoder
    import ir_nec_pkg::*;
#(
    parameter int CLK_DIV           = 50,
    parameter int LEAD_MARK_MIN_US  = 8000,
    parameter int DATA_SPACE_MIN_US = 3500,
    parameter int RPT_SPACE_MIN_US  = 1800,
    parameter int BIT_MARK_MAX_US   = 1000,
    parameter int BIT_ONE_MIN_US    = 1125,
    parameter int TIMEOUT_US        = 20000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ir_rx_n,
    input  logic        ack,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    output logic        repeat_valid,
    output logic        frame_error,
    output logic        data_ready,
    output state_t      o_dbg_state
);

    localparam logic [WIDTH_W-1:0]  LP_LEAD_MARK_MIN  = WIDTH_W'(LEAD_MARK_MIN_US);
    localparam logic [WIDTH_W-1:0]  LP_DATA_SPACE_MIN = WIDTH_W'(DATA_SPACE_MIN_US);
    localparam logic [WIDTH_W-1:0]  LP_RPT_SPACE_MIN  = WIDTH_W'(RPT_SPACE_MIN_US);
    localparam logic [WIDTH_W-1:0]  LP_BIT_MARK_MAX   = WIDTH_W'(BIT_MARK_MAX_US);
    localparam logic [WIDTH_W-1:0]  LP_BIT_ONE_MIN    = WIDTH_W'(BIT_ONE_MIN_US);
    localparam logic [WIDTH_W-1:0]  LP_TIMEOUT        = WIDTH_W'(TIMEOUT_US);
    localparam logic [BITCNT_W-1:0] LP_LAST_BIT       = BITCNT_W'(31);

    logic               w_fall;
    logic               w_rise;
    logic [WIDTH_W-1:0] w_width;
    logic               w_timeout;
    logic               w_bit;
    logic [31:0]        w_shift_next;
    logic               w_frame_ok;

    state_t              r_state;
    logic [BITCNT_W-1:0] r_bitcnt;
    logic [31:0]         r_shift;
    logic [31:0]         r_frame_data;
    logic                r_frame_valid;
    logic                r_repeat_valid;
    logic                r_frame_error;
    logic                r_data_ready;

    ir_pulse_timer #(
        .CLK_DIV    (CLK_DIV),
        .TIMEOUT_US (TIMEOUT_US)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .i_rx_n  (ir_rx_n),
        .o_fall  (w_fall),
        .o_rise  (w_rise),
        .o_width (w_width)
    );

    // A stuck line only matters once a frame has started; IDLE saturation is silent
    assign w_timeout = (r_state != ST_IDLE) && (w_width == LP_TIMEOUT);
    assign w_bit     = (w_width >= LP_BIT_ONE_MIN);

`ifdef IR_NEC_CHECKSUM_EN
    assign w_frame_ok = nec_checksum_ok(w_shift_next);
`else
    assign w_frame_ok = 1'b1;
`endif

    // Shift register image with the bit just decoded placed at the current index
    always_comb begin
        w_shift_next           = r_shift;
        w_shift_next[r_bitcnt] = w_bit;
    end

    // Frame decode FSM: walks leader and data bits on synchronized edges, drives strobes
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_bitcnt       <= '0;
            r_shift        <= '0;
            r_frame_data   <= '0;
            r_frame_valid  <= 1'b0;
            r_repeat_valid <= 1'b0;
            r_frame_error  <= 1'b0;
        end else begin
            r_frame_valid  <= 1'b0;
            r_repeat_valid <= 1'b0;
            r_frame_error  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state <= ST_LEAD_MARK;
                    end
                end
                ST_LEAD_MARK: begin
                    if (w_rise && (w_width >= LP_LEAD_MARK_MIN)) begin
                        r_state <= ST_LEAD_SPACE;
                    end else if (w_rise || w_timeout) begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_IDLE;
                        r_bitcnt      <= '0;
                    end
                end
                ST_LEAD_SPACE: begin
                    if (w_fall && (w_width >= LP_DATA_SPACE_MIN)) begin
                        r_state  <= ST_BIT_MARK;
                        r_bitcnt <= '0;
                        r_shift  <= '0;
                    end else if (w_fall && (w_width >= LP_RPT_SPACE_MIN)) begin
                        r_repeat_valid <= 1'b1;
                        r_state        <= ST_IDLE;
                    end else if (w_fall || w_timeout) begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_IDLE;
                        r_bitcnt      <= '0;
                    end
                end
                ST_BIT_MARK: begin
                    if (w_rise && (w_width <= LP_BIT_MARK_MAX)) begin
                        r_state <= ST_BIT_SPACE;
                    end else if (w_rise || w_timeout) begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_IDLE;
                        r_bitcnt      <= '0;
                    end
                end
                ST_BIT_SPACE: begin
                    if (w_fall) begin
                        r_shift <= w_shift_next;
                        if (r_bitcnt == LP_LAST_BIT) begin
                            // Stop mark is not checked; its rise is absorbed in IDLE
                            r_state  <= ST_IDLE;
                            r_bitcnt <= '0;
                            if (w_frame_ok) begin
                                r_frame_data  <= w_shift_next;
                                r_frame_valid <= 1'b1;
                            end else begin
                                r_frame_error <= 1'b1;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + BITCNT_W'(1);
                            r_state  <= ST_BIT_MARK;
                        end
                    end else if (w_timeout) begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_IDLE;
                        r_bitcnt      <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_bitcnt <= '0;
                end
            endcase
        end
    end

    // Sticky ready flag: a new frame wins over a coincident ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_ready <= 1'b0;
        end else if (r_frame_valid) begin
            r_data_ready <= 1'b1;
        end else if (ack) begin
            r_data_ready <= 1'b0;
        end
    end

    assign frame_data   = r_frame_data;
    assign frame_valid  = r_frame_valid;
    assign repeat_valid = r_repeat_valid;
    assign frame_error  = r_frame_error;
    assign data_ready   = r_data_ready;
    assign o_dbg_state  = r_state;

endmodule
